// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the fetch stage: FSM states, bubble
// instruction, default reset PC and the IF/D entry layout.
package riscv_fetch_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch unit (master) and memory.
interface instruction_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Prefetch FIFO of {addr, instr} entries; flush wins over push, head is
// read straight from the storage registers.
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_flush,
    input  fetch_entry_t                 i_data,
    output fetch_entry_t                 o_head,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_full,
    output logic                         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_push;
    logic           w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the imem req/ack bus through a prefetch
// FIFO and presents {pc, instr} to the IF/D register.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = riscv_fetch_pkg::DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = riscv_fetch_pkg::NOP_INSTR
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     IFD_register_hold,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    instruction_fetch_unit_if.master imem,
    output logic [31:0]              address_bus_IR,
    output logic [31:0]              inst_mem_bus_IR,
    output logic                     fetch_valid
);
    import riscv_fetch_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  r_state;
    logic [31:0]   r_pc;
    logic          r_req;
    logic [31:0]   r_addr;

    fetch_state_t  w_state_next;
    logic [31:0]   w_pc_next;
    logic          w_req_next;
    logic [31:0]   w_addr_next;
    logic [CW-1:0] w_count_next;
    logic          w_ack;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_data;

    assign w_push_data = '{addr: r_addr, instr: imem.imem_rdata};

    always_comb begin
        // An ack only counts while our own request is actually up.
        w_ack        = r_req && imem.imem_ack;
        w_pop        = !w_empty && !IFD_register_hold && !redirect_valid;
        w_push       = w_ack && (r_state != DRAIN) && !redirect_valid && (!w_full || w_pop);
        w_state_next = r_state;
        w_pc_next    = r_pc;
        if (w_ack && (r_state != DRAIN)) w_pc_next = r_pc + 32'd4;
        case (r_state)
            REQ:     if (r_req && !w_ack) w_state_next = redirect_valid ? DRAIN : WAIT;
            WAIT:    if (w_ack) w_state_next = REQ;
                     else if (redirect_valid) w_state_next = DRAIN;
            DRAIN:   if (w_ack) w_state_next = REQ;
            default: w_state_next = REQ;
        endcase
        if (redirect_valid) w_pc_next = redirect_pc & ~32'h3;

        w_count_next = redirect_valid ? '0 : (w_count + CW'(w_push) - CW'(w_pop));
        // Request for next cycle only if the FIFO will have room after this edge.
        if (w_state_next == REQ) begin
            w_req_next  = (w_count_next < CW'(FIFO_DEPTH));
            w_addr_next = w_pc_next;
        end else begin
            w_req_next  = 1'b1;
            w_addr_next = r_addr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= REQ;
            r_pc    <= RESET_PC;
            r_req   <= 1'b0;
            r_addr  <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_req   <= w_req_next;
            r_addr  <= w_addr_next;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .srst    (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign imem.imem_req   = r_req;
    assign imem.imem_addr  = r_addr;
    assign fetch_valid     = !w_empty;
    assign address_bus_IR  = w_empty ? 32'h0 : w_head.addr;
    assign inst_mem_bus_IR = w_empty ? NOP_INSTR : w_head.instr;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a streaming/hold vector table plus
// hand-written sequences for slow memory, redirects, reset and PC wrap.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic        hold;
    logic        redir_v;
    logic [31:0] redir_pc;
    logic [31:0] abus;
    logic [31:0] ibus;
    logic        fvalid;

    int n_cmp = 0;
    int n_bad = 0;

    instruction_fetch_unit_if imem_bus ();

    instruction_fetch_unit dut (
        .clock             (clock),
        .reset             (reset),
        .IFD_register_hold (hold),
        .redirect_valid    (redir_v),
        .redirect_pc       (redir_pc),
        .imem              (imem_bus),
        .address_bus_IR    (abus),
        .inst_mem_bus_IR   (ibus),
        .fetch_valid       (fvalid)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        hold;
        logic        ack;
        logic [31:0] rdata;
        logic        exp_req;
        logic        chk_addr;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_abus;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge: compares the current-cycle outputs.
    task automatic chk_out(input string tag, input logic e_req, input logic c_addr,
                           input logic [31:0] e_addr, input logic e_valid,
                           input logic [31:0] e_abus, input logic [31:0] e_inst);
        $display("%s: req=%b addr=%h valid=%b pc=%h inst=%h", tag,
                 imem_bus.imem_req, imem_bus.imem_addr, fvalid, abus, ibus);
        chk({tag, " imem_req"}, 32'(imem_bus.imem_req), 32'(e_req));
        if (c_addr) chk({tag, " imem_addr"}, imem_bus.imem_addr, e_addr);
        chk({tag, " fetch_valid"}, 32'(fvalid), 32'(e_valid));
        chk({tag, " address_bus_IR"}, abus, e_abus);
        chk({tag, " inst_mem_bus_IR"}, ibus, e_inst);
    endtask

    // Drive this cycle's inputs and advance to the next negedge.
    task automatic drive(input logic h, input logic a, input logic [31:0] d,
                         input logic rv, input logic [31:0] rp);
        hold                = h;
        imem_bus.imem_ack   = a;
        imem_bus.imem_rdata = d;
        redir_v             = rv;
        redir_pc            = rp;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic        ev;
        logic [31:0] ea;
        logic [31:0] ei;

        // hold, ack, rdata, exp_req, chk_addr, exp_addr, exp_valid, exp_abus, exp_inst
        vecs[0]  = '{1'b0, 1'b1, 32'hA5A5_0000, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00, NOP};
        vecs[1]  = '{1'b0, 1'b1, 32'hA5A5_0000, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, NOP};
        vecs[2]  = '{1'b0, 1'b1, 32'hA5A5_0004, 1'b1, 1'b1, 32'h04, 1'b1, 32'h00, 32'hA5A5_0000};
        vecs[3]  = '{1'b0, 1'b1, 32'hA5A5_0008, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04, 32'hA5A5_0004};
        vecs[4]  = '{1'b0, 1'b1, 32'hA5A5_000C, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h08, 32'hA5A5_0008};
        vecs[5]  = '{1'b1, 1'b1, 32'hA5A5_0010, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C, 32'hA5A5_000C};
        vecs[6]  = '{1'b1, 1'b1, 32'hA5A5_0014, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0C, 32'hA5A5_000C};
        vecs[7]  = vecs[6];
        vecs[8]  = vecs[6];
        vecs[9]  = vecs[6];
        vecs[10] = '{1'b0, 1'b1, 32'hA5A5_0014, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0C, 32'hA5A5_000C};
        vecs[11] = '{1'b0, 1'b1, 32'hA5A5_0014, 1'b1, 1'b1, 32'h14, 1'b1, 32'h10, 32'hA5A5_0010};
        vecs[12] = '{1'b0, 1'b1, 32'hA5A5_0018, 1'b1, 1'b1, 32'h18, 1'b1, 32'h14, 32'hA5A5_0014};
        vecs[13] = '{1'b0, 1'b1, 32'hA5A5_001C, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h18, 32'hA5A5_0018};

        reset = 1'b1;
        hold = 1'b0; redir_v = 1'b0; redir_pc = 32'h0;
        imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'h0;

        // Streaming fetch, then a 5-cycle hold and release.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            chk_out($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].chk_addr, vecs[i].exp_addr,
                    vecs[i].exp_valid, vecs[i].exp_abus, vecs[i].exp_inst);
            drive(vecs[i].hold, vecs[i].ack, vecs[i].rdata, 1'b0, 32'h0);
        end

        // Memory answers on the 4th cycle of every request.
        do_reset();
        chk_out("slow c0", 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, NOP);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                ev = (j == 0) && (k > 0);
                ea = ev ? 32'(4 * (k - 1)) : 32'h0;
                ei = ev ? 32'h1111_0000 + 32'(k - 1) : NOP;
                chk_out($sformatf("slow w%0d c%0d", k, j), 1'b1, 1'b1, 32'(4 * k), ev, ea, ei);
                drive(1'b0, (j == 3), 32'h1111_0000 + 32'(k), 1'b0, 32'h0);
            end
        end
        chk_out("slow end", 1'b1, 1'b1, 32'h0C, 1'b1, 32'h08, 32'h1111_0002);

        // Redirect while waiting at 0x10, then redirect against pop+ack, then reset in WAIT.
        do_reset();
        chk_out("rdw c0", 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, NOP);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h10);
        chk_out("rdw c1", 1'b1, 1'b1, 32'h10, 1'b0, 32'h0, NOP);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_out("rdw c2", 1'b1, 1'b1, 32'h10, 1'b0, 32'h0, NOP);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0103);
        chk_out("rdw c3", 1'b1, 1'b1, 32'h10, 1'b0, 32'h0, NOP);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_out("rdw c4", 1'b1, 1'b1, 32'h10, 1'b0, 32'h0, NOP);
        drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
        chk_out("rdw c5", 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, NOP);
        drive(1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0);
        chk_out("rdw c6", 1'b1, 1'b1, 32'h104, 1'b1, 32'h100, 32'h1234_5678);
        drive(1'b0, 1'b1, 32'h5555_5555, 1'b1, 32'h200);
        chk_out("rpop c7", 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, NOP);
        drive(1'b0, 1'b1, 32'h2222_0000, 1'b0, 32'h0);
        chk_out("rpop c8", 1'b1, 1'b1, 32'h204, 1'b1, 32'h200, 32'h2222_0000);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_out("rst c9", 1'b1, 1'b1, 32'h204, 1'b1, 32'h200, 32'h2222_0000);
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_out("rst c10", 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, NOP);
        reset = 1'b0;
        drive(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 32'h0);
        chk_out("rst c11", 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, NOP);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_out("rst c12", 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, NOP);

        // Redirect near the top of the address space; low bits of the target are dropped.
        do_reset();
        chk_out("wrap c0", 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, NOP);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
        chk_out("wrap c1", 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, NOP);
        drive(1'b0, 1'b1, 32'h3333_0000, 1'b0, 32'h0);
        chk_out("wrap c2", 1'b1, 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h3333_0000);
        drive(1'b0, 1'b1, 32'h4444_0000, 1'b0, 32'h0);
        chk_out("wrap c3", 1'b1, 1'b1, 32'h4, 1'b1, 32'h0, 32'h4444_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
